// File: rtl/rr_sched_pkg.sv
// Shared types and helpers for the round-robin register write scheduler.
// Helpers work at the maximum supported requester count and are narrowed by callers.
package rr_sched_pkg;

  localparam int MAXREQ = 8;
  localparam int IW     = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  typedef struct packed {
    logic          found;
    logic [IW-1:0] idx;
  } pick_t;

  function automatic logic [MAXREQ-1:0] onehot(input logic [IW-1:0] idx, input int n);
    logic [MAXREQ-1:0] v;
    v = '0;
    if (int'(idx) < n) v[idx] = 1'b1;
    return v;
  endfunction

  // Rotating-priority search: first set request at or after ptr, wrapping at n-1.
  function automatic pick_t rr_pick(input logic [MAXREQ-1:0] req,
                                    input logic [IW-1:0]     ptr,
                                    input int                n);
    pick_t         r;
    int            j;
    logic [IW-1:0] jj;
    r = '0;
    for (int k = 0; k < MAXREQ; k++) begin
      if (k < n && !r.found) begin
        j  = (int'(ptr) + k) % n;
        jj = IW'(j);
        if (req[jj]) begin
          r.found = 1'b1;
          r.idx   = jj;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick_comb.sv
// Purely combinational rotate-priority winner search over NREQ requesters.
module rr_pick_comb
  import rr_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   win,
  output logic            found
);

  pick_t p;

  always_comb begin
    p     = rr_pick(MAXREQ'(req), IW'(ptr), NREQ);
    win   = PW'(p.idx);
    found = p.found;
  end

endmodule

// File: rtl/rr_reg_write_sched.sv
// Round-robin arbiter sharing one write port of a small register array,
// with a sequential clear engine that wipes one entry per cycle.
module rr_reg_write_sched
  import rr_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DW    = 4,
  parameter int DEPTH = 3,
  parameter int AW    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_i  [NREQ],
  input  logic [AW-1:0]       addr_i [NREQ],
  input  logic [DW-1:0]       data_i [NREQ],
  input  logic                clr_i,
  output logic [NREQ-1:0]     gnt_o,
  output logic [DW-1:0]       regs_o [DEPTH],
  output logic [DEPTH-1:0]    vld_o,
  output logic                err_o,
  output logic                busy_o
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e          state, state_n;
  logic [PW-1:0]   ptr, ptr_n;
  logic [CW-1:0]   cidx, cidx_n;
  logic [NREQ-1:0] reqv;
  logic [PW-1:0]   win;
  logic            found;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic            in_range;
  logic            wr_en, clr_en, err_n, busy_n;
  logic [NREQ-1:0] gnt_n;

  always_comb begin
    for (int k = 0; k < NREQ; k++) reqv[k] = req_i[k];
  end

  rr_pick_comb #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req   (reqv),
    .ptr   (ptr),
    .win   (win),
    .found (found)
  );

  assign sel_addr = addr_i[win];
  assign sel_data = data_i[win];
  // One extra bit so the bound check still works when DEPTH == 2**AW.
  assign in_range = ({1'b0, sel_addr} < (AW+1)'(DEPTH));

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cidx_n  = cidx;
    gnt_n   = '0;
    err_n   = 1'b0;
    busy_n  = busy_o;
    wr_en   = 1'b0;
    clr_en  = 1'b0;
    case (state)
      IDLE: begin
        if (clr_i) begin
          state_n = CLEAR;
          busy_n  = 1'b1;
          cidx_n  = '0;
        end else if (found) begin
          gnt_n = NREQ'(onehot(IW'(win), NREQ));
          ptr_n = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
          if (in_range) wr_en = 1'b1;
          else          err_n = 1'b1;
        end
      end
      CLEAR: begin
        clr_en = 1'b1;
        if (cidx == CW'(DEPTH - 1)) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          cidx_n  = '0;
        end else begin
          cidx_n = cidx + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= '0;
      cidx   <= '0;
      gnt_o  <= '0;
      err_o  <= 1'b0;
      busy_o <= 1'b0;
      vld_o  <= '0;
      for (int e = 0; e < DEPTH; e++) regs_o[e] <= '0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      cidx   <= cidx_n;
      gnt_o  <= gnt_n;
      err_o  <= err_n;
      busy_o <= busy_n;
      for (int e = 0; e < DEPTH; e++) begin
        if (wr_en && sel_addr == AW'(e)) begin
          regs_o[e] <= sel_data;
          vld_o[e]  <= 1'b1;
        end else if (clr_en && cidx == CW'(e)) begin
          regs_o[e] <= '0;
          vld_o[e]  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rr_reg_write_sched.sv
// Scoreboard bench: directed vectors push hand-computed expected outputs,
// a monitor pops and compares them one cycle after each vector is applied.
module tb_rr_reg_write_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req   [4];
  logic [1:0] addr  [4];
  logic [3:0] data  [4];
  logic       clr = 1'b0;
  logic [3:0] gnt;
  logic [3:0] regs  [3];
  logic [2:0] vld;
  logic       err;
  logic       busy;

  typedef struct {
    int         due;
    string      name;
    logic [3:0] gnt;
    logic       err;
    logic       busy;
    logic [2:0] vld;
    logic [11:0] regs;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 1'b0;

  rr_reg_write_sched #(.NREQ(4), .DW(4), .DEPTH(3), .AW(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (req),
    .addr_i (addr),
    .data_i (data),
    .clr_i  (clr),
    .gnt_o  (gnt),
    .regs_o (regs),
    .vld_o  (vld),
    .err_o  (err),
    .busy_o (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input string field,
                             input logic [15:0] act, input logic [15:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s.%s got %h want %h", name, field, act, want);
    end
  endtask

  // addrs packs {a3,a2,a1,a0}, datas packs {d3,d2,d1,d0}, eregs packs {r2,r1,r0}
  task automatic applyStimulus(input string name, input logic rn, input logic c,
                               input logic [3:0] rq, input logic [7:0] addrs,
                               input logic [15:0] datas, input logic [3:0] egnt,
                               input logic eerr, input logic ebusy,
                               input logic [2:0] evld, input logic [11:0] eregs);
    exp_t e;
    @(negedge clk);
    rst_n = rn;
    clr   = c;
    for (int k = 0; k < 4; k++) begin
      req[k]  = rq[k];
      addr[k] = addrs[2*k +: 2];
      data[k] = datas[4*k +: 4];
    end
    e.due  = cyc + 1;
    e.name = name;
    e.gnt  = egnt;
    e.err  = eerr;
    e.busy = ebusy;
    e.vld  = evld;
    e.regs = eregs;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        checkOutput(e.name, "gnt",  16'(gnt),  16'(e.gnt));
        checkOutput(e.name, "err",  16'(err),  16'(e.err));
        checkOutput(e.name, "busy", 16'(busy), 16'(e.busy));
        checkOutput(e.name, "vld",  16'(vld),  16'(e.vld));
        checkOutput(e.name, "regs", 16'({regs[2], regs[1], regs[0]}), 16'(e.regs));
      end
    end
  end

  initial begin : stimulus
    int waited;
    for (int k = 0; k < 4; k++) begin
      req[k] = 1'b0; addr[k] = '0; data[k] = '0;
    end

    applyStimulus("rst0",   0, 0, 4'b0000, 8'h00, 16'h0000, 4'b0000, 0, 0, 3'b000, 12'h000);
    applyStimulus("rst1",   0, 0, 4'b0000, 8'h00, 16'h0000, 4'b0000, 0, 0, 3'b000, 12'h000);
    applyStimulus("idle",   1, 0, 4'b0000, 8'h00, 16'h0000, 4'b0000, 0, 0, 3'b000, 12'h000);
    applyStimulus("single", 1, 0, 4'b0100, 8'h10, 16'h0A00, 4'b0100, 0, 0, 3'b010, 12'h0A0);
    applyStimulus("idle2",  1, 0, 4'b0000, 8'h10, 16'h0A00, 4'b0000, 0, 0, 3'b010, 12'h0A0);
    applyStimulus("rstptr", 0, 0, 4'b0000, 8'h00, 16'h0000, 4'b0000, 0, 0, 3'b000, 12'h000);

    applyStimulus("rr1", 1, 0, 4'b1111, 8'h24, 16'h4321, 4'b0001, 0, 0, 3'b001, 12'h001);
    applyStimulus("rr2", 1, 0, 4'b1111, 8'h24, 16'h4321, 4'b0010, 0, 0, 3'b011, 12'h021);
    applyStimulus("rr3", 1, 0, 4'b1111, 8'h24, 16'h4321, 4'b0100, 0, 0, 3'b111, 12'h321);
    applyStimulus("rr4", 1, 0, 4'b1111, 8'h24, 16'h4321, 4'b1000, 0, 0, 3'b111, 12'h324);
    applyStimulus("rr5", 1, 0, 4'b1111, 8'h24, 16'h4321, 4'b0001, 0, 0, 3'b111, 12'h321);
    applyStimulus("rr6", 1, 0, 4'b1111, 8'h24, 16'h4321, 4'b0010, 0, 0, 3'b111, 12'h321);
    applyStimulus("rr7", 1, 0, 4'b1111, 8'h24, 16'h4321, 4'b0100, 0, 0, 3'b111, 12'h321);
    applyStimulus("rr8", 1, 0, 4'b1111, 8'h24, 16'h4321, 4'b1000, 0, 0, 3'b111, 12'h324);

    applyStimulus("badaddr", 1, 0, 4'b0001, 8'h03, 16'h0005, 4'b0001, 1, 0, 3'b111, 12'h324);
    applyStimulus("errdrop", 1, 0, 4'b0000, 8'h03, 16'h0005, 4'b0000, 0, 0, 3'b111, 12'h324);

    applyStimulus("clrreq",  1, 1, 4'b0010, 8'h04, 16'h0070, 4'b0000, 0, 1, 3'b111, 12'h324);
    applyStimulus("clr0",    1, 1, 4'b0010, 8'h04, 16'h0070, 4'b0000, 0, 1, 3'b110, 12'h320);
    applyStimulus("clr1",    1, 1, 4'b0010, 8'h04, 16'h0070, 4'b0000, 0, 1, 3'b100, 12'h300);
    applyStimulus("clr2",    1, 0, 4'b0010, 8'h04, 16'h0070, 4'b0000, 0, 0, 3'b000, 12'h000);
    applyStimulus("postclr", 1, 0, 4'b0010, 8'h04, 16'h0070, 4'b0010, 0, 0, 3'b010, 12'h070);

    applyStimulus("same0", 1, 0, 4'b0011, 8'h0A, 16'h0098, 4'b0001, 0, 0, 3'b110, 12'h870);
    applyStimulus("same1", 1, 0, 4'b0010, 8'h0A, 16'h0098, 4'b0010, 0, 0, 3'b110, 12'h970);

    applyStimulus("mclr",     1, 1, 4'b0000, 8'h00, 16'h0000, 4'b0000, 0, 1, 3'b110, 12'h970);
    applyStimulus("mclr0",    1, 0, 4'b0000, 8'h00, 16'h0000, 4'b0000, 0, 1, 3'b110, 12'h970);
    applyStimulus("mrst",     0, 0, 4'b0000, 8'h00, 16'h0000, 4'b0000, 0, 0, 3'b000, 12'h000);
    applyStimulus("afterrst", 1, 0, 4'b1010, 8'h40, 16'hC0F0, 4'b0010, 0, 0, 3'b001, 12'h00F);
    applyStimulus("final",    1, 0, 4'b0000, 8'h40, 16'hC0F0, 4'b0000, 0, 0, 3'b001, 12'h00F);

    stim_done = 1'b1;
    waited = 0;
    while (q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain pending %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_reg_write_sched.md
Name: rr_reg_write_sched

Overview:
- Round-robin write scheduler that shares one write port of a small register-array resource between NREQ requesters.
- The array is DEPTH entries of DW bits, exposed as an unpacked output array in the same style as the generated test modules.
- Includes a sequential clear engine that wipes entries one per cycle.
- Sits between fuzz-generated producer modules and the array they drive, replacing multi-driven assigns with a single arbitrated driver.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 4, data width of each array entry.
- DEPTH, 3, number of array entries.
- AW, 2, address width; must satisfy 2**AW >= DEPTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req_i  input  unpacked [NREQ] x 1  write request per requester; level, held until granted.
- addr_i  input  unpacked [NREQ] x AW  target entry per requester.
- data_i  input  unpacked [NREQ] x DW  write data per requester.
- clr_i  input  1  start sequential clear (pulse or level).
- gnt_o  output  NREQ  registered one-hot grant; requester k was served at this edge.
- regs_o  output  unpacked [DEPTH] x DW  current array contents.
- vld_o  output  DEPTH  per-entry written-since-clear flag.
- err_o  output  1  registered pulse: granted write had addr >= DEPTH and was dropped.
- busy_o  output  1  high while the clear engine is running.

Behaviour:
- Reset (rst_n low at a clock edge) forces:
  - gnt_o = 0, regs_o all 0, vld_o = 0, err_o = 0, busy_o = 0.
  - FSM = IDLE, priority pointer ptr = 0, clear index cidx = 0.
  - Reset mid-clear aborts the clear; the state is fully reinitialised.
- FSM states:
  - IDLE: arbitration active.
  - CLEAR: one entry cleared per cycle.
- IDLE arbitration (each cycle):
  - Search requesters starting at index ptr, ascending with wrap at NREQ-1 -> 0. The first one with req_i high is the winner w.
  - At the edge: gnt_o <= onehot(w), ptr <= (w+1) mod NREQ.
  - If addr_i[w] < DEPTH: regs_o[addr_i[w]] <= data_i[w], vld_o bit set.
  - Else the write is dropped and err_o <= 1.
  - No request: gnt_o <= 0, ptr unchanged, err_o <= 0.
- Latency: a request sampled at edge N shows gnt_o and the updated regs_o after edge N. A requester drops req_i on seeing its gnt_o, so it may be granted twice if it holds req_i through the grant cycle; this is legal.
- Fairness: a continuously asserted requester is granted at least once every NREQ cycles.
- clr_i while in IDLE:
  - clr_i has priority over arbitration in the same cycle: no grant, no write, gnt_o <= 0.
  - Go to CLEAR, busy_o <= 1, cidx <= 0.
- CLEAR state, each cycle:
  - regs_o[cidx] <= 0, vld_o[cidx] <= 0, cidx <= cidx+1, gnt_o <= 0, err_o <= 0.
  - On the cycle clearing cidx = DEPTH-1: go to IDLE, busy_o <= 0.
  - Total: DEPTH cycles busy.
  - clr_i during CLEAR is ignored (no restart).
  - Requests are stalled, not lost: they remain pending on req_i.
- ptr is unchanged across a clear.
- Two requesters targeting the same address: only the winner writes; the other writes in a later grant cycle (last-granted wins).
- Width rules: the addr compare is unsigned, at width AW. cidx is sized clog2(DEPTH) and never exceeds DEPTH-1.

Decomposition:
- Package rr_sched_pkg:
  - typedef state_e {IDLE, CLEAR}.
  - Function onehot(idx, n).
  - Function rr_pick(req, ptr) returning winner index and a found flag.
- One natural sub-module: rr_pick_comb, the purely combinational rotate-priority search.
- The top module holds the FSM, the array registers and the clear engine.

Test Plan:
- Reset then idle: rst_n=0 two cycles, release, no req -> gnt_o=0, regs_o={0,0,0}, vld_o=3'b000, busy_o=0.
- Single writer: req_i[2]=1, addr 1, data 4'hA for one cycle -> next cycle gnt_o=4'b0100, regs_o[1]=4'hA, vld_o=3'b010, err_o=0.
- Round-robin fairness: all four req held 8 cycles, distinct addrs/data -> gnt_o sequence 0001,0010,0100,1000,0001,... with no requester skipped.
- Bad address: req_i[0]=1, addr 3 (DEPTH=3), data 4'h5 -> gnt_o=0001, err_o=1 for one cycle, regs_o unchanged.
- Clear vs request:
  - Preload all entries, then assert clr_i together with req_i[1].
  - Required: busy_o=1 for exactly 3 cycles, regs cleared in order 0,1,2, gnt_o=0 throughout.
  - req_i[1] granted on the first cycle after busy_o falls.
- Reset mid-clear: assert rst_n=0 at the second CLEAR cycle -> next cycle busy_o=0, all regs 0, ptr=0 (first grant goes to the lowest active requester).
